cpu_regfile: RTL and testbench
==============================

# cpu_regfile

General-purpose register file and operand source for the CPU datapath. It sits directly upstream of the ALU and drives `ALU_input0` and `ALU_input1` from B, C, D, E, H, L, SP, the WZ temporary pair, or the ALU-owned A/F. It also takes results back from `ALU_out` one cycle after the ALU registers them, and drives the 16-bit memory address from a selected pair. It includes a one-deep pending-writeback stage with optional operand forwarding.

## Interface
Parameters:
- `RESET_SP`, 16'hFFFE: SP value after reset.
- `RESET_GPR`, 8'h00: value of B, C, D, E, H, L, W, Z after reset.

Ports:
- `clk4_2`, in, 1: datapath clock, rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `A`, in, 8: accumulator from the ALU, read-only here.
- `F`, in, 8: flags from the ALU, read-only here.
- `ALU_out`, in, 16: registered ALU result.
- `data_bus`, in, 8: byte from the memory interface.
- `rd0_sel`, in, 4: operand-0 select.
- `rd1_sel`, in, 4: operand-1 select.
- `addr_sel`, in, 4: address select; 16-bit codes only.
- `wr_en`, in, 1: direct write from `data_bus` this cycle.
- `wr_sel`, in, 4: direct write target.
- `wr_hi`, in, 1: for a pair target, selects the high byte (1) or low byte (0).
- `wb_req`, in, 1: asserted with the ALU's `ALU_OUT_WR`; requests writeback of `ALU_out` next cycle.
- `wb_sel`, in, 4: writeback target.
- `ALU_input0`, out, 16: operand 0, combinational.
- `ALU_input1`, out, 16: operand 1, combinational.
- `addr_out`, out, 16: memory address, combinational.
- `wb_pending`, out, 1: writeback stage occupied.

## Operation
- Select encoding:
  - 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 A, 7 F.
  - 8 BC, 9 DE, 10 HL, 11 SP, 12 AF, 13 WZ, 14 W, 15 constant 0.
- 8-bit codes are zero-extended to 16 bits.
- Pair codes place the first-named register in [15:8].
- Direct write (`wr_en`):
  - 8-bit target: the register takes `data_bus`.
  - Pair target: `wr_hi` selects which byte takes `data_bus`.
  - Targets 6, 7, 12 and 15 are ignored; A and F belong to the ALU.
- Writeback stage:
  - Cycle N, `wb_req`=1: latch `wb_sel` into `wb_tgt` and set `wb_pending`.
  - Cycle N+1: `ALU_out` is valid. At the N+1 edge, write `ALU_out[7:0]` for an 8-bit target, or the full 16 bits for a pair.
  - `wb_pending` clears at that edge unless `wb_req` is asserted again in N+1 (back-to-back requests are allowed; throughput 1/cycle).
  - `wb_tgt` codes 6, 7, 12 and 15 are dropped silently; `wb_pending` still pulses.
- Collision: if a direct write and the pending writeback hit the same byte on the same edge, the direct write wins. Non-overlapping bytes of the writeback are still written.
- Writes to W (14) update WZ[15:8].
- Writes to SP as two bytes are allowed (`wr_hi` selects the byte).

## Timing
- Reset (asynchronous):
  - B, C, D, E, H, L, W, Z = `RESET_GPR`; SP = `RESET_SP`.
  - `wb_pending` = 0; `wb_tgt` = 0.
  - Outputs then reflect those values: `ALU_input*` and `addr_out` follow the selects.
- Read latency is 0 (combinational from the selects and register state).
- Direct-write latency: the new value is visible on reads in the cycle after the `wr_en` edge.
- Writeback latency: `wb_req` in cycle N; the register is updated at the end of N+1; the value is visible from the regfile in N+2.
- Reset mid-writeback: a pending write is discarded; no partial update.

## Configuration
- `CPU_REGFILE_BYPASS_EN` defined:
  - While `wb_pending` is set, any read or address select that overlaps `wb_tgt` takes the overlapping bytes from `ALU_out` instead of the register.
  - Example: `wb_tgt`=H with `rd0_sel`=HL gives {`ALU_out[7:0]`, L}.
  - A direct `wr_en` in the same cycle is not forwarded.
- Undefined: no forwarding. Reads in cycle N+1 return the old value, and the sequencer must insert one cycle of spacing.

## Structure
- Shared package (`cpu_pkg`):
  - Select-code constants (`SEL_B` … `SEL_ZERO`).
  - Reset-value constants.
  - `is_pair(sel)` and byte-mask helper functions.
- Natural sub-module: `regfile_read_mux`. Instantiated three times (rd0, rd1, addr), it performs select decode, pair assembly and the optional bypass overlay.

## Test plan
- Reset → `rd0_sel`=SP gives `ALU_input0`=16'hFFFE; `rd1_sel`=BC gives 16'h0000; `wb_pending`=0.
- Direct writes: `wr_en`, `wr_sel`=HL, `wr_hi`=1 with `data_bus`=8'hC0, then `wr_hi`=0 with 8'h12 → `addr_sel`=HL gives 16'hC012.
- Writeback: `wb_req` with `wb_sel`=DE in N, `ALU_out`=16'hBEEF in N+1 → `rd0_sel`=DE gives 16'hBEEF in N+2.
- Bypass, with `CPU_REGFILE_BYPASS_EN`: `wb_tgt`=C, `ALU_out`=16'h0055, `rd1_sel`=BC in N+1 → `ALU_input1`={B, 8'h55}. Without the macro, the old C is returned.
- Collision: a pending writeback to HL (`ALU_out`=16'h1234) together with a direct write to H of 8'hAA on the same edge → HL=16'hAA34.
- Mid-writeback reset: `wb_req` in N, `reset_n` low in N+1 → target keeps `RESET_GPR`; `wb_pending`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: select codes, reset defaults and byte-lane helpers shared by the register file.
// Byte lanes: 0 C, 1 B, 2 E, 3 D, 4 L, 5 H, 6 Z, 7 W, 8 SP lo, 9 SP hi (pair high byte is the odd lane).
package cpu_pkg;
    localparam logic [3:0] SEL_B    = 4'd0;
    localparam logic [3:0] SEL_C    = 4'd1;
    localparam logic [3:0] SEL_D    = 4'd2;
    localparam logic [3:0] SEL_E    = 4'd3;
    localparam logic [3:0] SEL_H    = 4'd4;
    localparam logic [3:0] SEL_L    = 4'd5;
    localparam logic [3:0] SEL_A    = 4'd6;
    localparam logic [3:0] SEL_F    = 4'd7;
    localparam logic [3:0] SEL_BC   = 4'd8;
    localparam logic [3:0] SEL_DE   = 4'd9;
    localparam logic [3:0] SEL_HL   = 4'd10;
    localparam logic [3:0] SEL_SP   = 4'd11;
    localparam logic [3:0] SEL_AF   = 4'd12;
    localparam logic [3:0] SEL_WZ   = 4'd13;
    localparam logic [3:0] SEL_W    = 4'd14;
    localparam logic [3:0] SEL_ZERO = 4'd15;

    localparam int NUM_BYTES = 10;
    localparam logic [NUM_BYTES-1:0] HI_BYTES = 10'b10_1010_1010;
    localparam logic [15:0] RESET_SP_DEF  = 16'hFFFE;
    localparam logic [7:0]  RESET_GPR_DEF = 8'h00;

    function automatic logic is_pair(input logic [3:0] sel);
        return sel[3] && sel != SEL_W && sel != SEL_ZERO;
    endfunction

    // Lanes owned by this file that a select covers; A/F/AF/zero own none.
    function automatic logic [NUM_BYTES-1:0] byte_mask(input logic [3:0] sel);
        case (sel)
            SEL_B:   return 10'b00_0000_0010;
            SEL_C:   return 10'b00_0000_0001;
            SEL_D:   return 10'b00_0000_1000;
            SEL_E:   return 10'b00_0000_0100;
            SEL_H:   return 10'b00_0010_0000;
            SEL_L:   return 10'b00_0001_0000;
            SEL_W:   return 10'b00_1000_0000;
            SEL_BC:  return 10'b00_0000_0011;
            SEL_DE:  return 10'b00_0000_1100;
            SEL_HL:  return 10'b00_0011_0000;
            SEL_WZ:  return 10'b00_1100_0000;
            SEL_SP:  return 10'b11_0000_0000;
            default: return 10'b00_0000_0000;
        endcase
    endfunction
endpackage

// File: rtl/regfile_read_mux.sv
// regfile_read_mux: decodes one select into a zero-extended byte or an assembled pair,
// with forwarded lanes overlaid on the stored register bytes.
module regfile_read_mux
    import cpu_pkg::*;
(
    input  logic [3:0]                 sel,
    input  logic [NUM_BYTES-1:0][7:0]  regs,
    input  logic [7:0]                 a,
    input  logic [7:0]                 f,
    input  logic [NUM_BYTES-1:0]       fwd_mask,
    input  logic [NUM_BYTES-1:0][7:0]  fwd_bytes,
    output logic [15:0]                data
);
    logic [NUM_BYTES-1:0][7:0] v;

    always_comb begin
        for (int i = 0; i < NUM_BYTES; i++)
            v[i] = fwd_mask[i] ? fwd_bytes[i] : regs[i];
        case (sel)
            SEL_B:   data = {8'h00, v[1]};
            SEL_C:   data = {8'h00, v[0]};
            SEL_D:   data = {8'h00, v[3]};
            SEL_E:   data = {8'h00, v[2]};
            SEL_H:   data = {8'h00, v[5]};
            SEL_L:   data = {8'h00, v[4]};
            SEL_A:   data = {8'h00, a};
            SEL_F:   data = {8'h00, f};
            SEL_BC:  data = {v[1], v[0]};
            SEL_DE:  data = {v[3], v[2]};
            SEL_HL:  data = {v[5], v[4]};
            SEL_SP:  data = {v[9], v[8]};
            SEL_AF:  data = {a, f};
            SEL_WZ:  data = {v[7], v[6]};
            SEL_W:   data = {8'h00, v[7]};
            default: data = 16'h0000;
        endcase
    end
endmodule

// File: rtl/cpu_regfile.sv
// cpu_regfile: register file and ALU operand source with a one-deep ALU writeback stage.
// Define CPU_REGFILE_BYPASS_EN to forward the pending writeback onto all read ports.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_SP  = RESET_SP_DEF,
    parameter logic [7:0]  RESET_GPR = RESET_GPR_DEF
) (
    input  logic        clk4_2,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  F,
    input  logic [15:0] ALU_out,
    input  logic [7:0]  data_bus,
    input  logic [3:0]  rd0_sel,
    input  logic [3:0]  rd1_sel,
    input  logic [3:0]  addr_sel,
    input  logic        wr_en,
    input  logic [3:0]  wr_sel,
    input  logic        wr_hi,
    input  logic        wb_req,
    input  logic [3:0]  wb_sel,
    output logic [15:0] ALU_input0,
    output logic [15:0] ALU_input1,
    output logic [15:0] addr_out,
    output logic        wb_pending
);
    logic [NUM_BYTES-1:0][7:0] regs;
    logic [NUM_BYTES-1:0][7:0] wb_bytes;
    logic [NUM_BYTES-1:0]      wb_mask;
    logic [NUM_BYTES-1:0]      wr_mask;
    logic [NUM_BYTES-1:0]      fwd_mask;
    logic [3:0]                wb_tgt;

    always_comb begin
        wb_mask = wb_pending ? byte_mask(wb_tgt) : '0;
        wr_mask = wr_en ? byte_mask(wr_sel) & (is_pair(wr_sel) ? (wr_hi ? HI_BYTES : ~HI_BYTES) : '1) : '0;
        for (int i = 0; i < NUM_BYTES; i++)
            wb_bytes[i] = (is_pair(wb_tgt) && i % 2 == 1) ? ALU_out[15:8] : ALU_out[7:0];
    end

`ifdef CPU_REGFILE_BYPASS_EN
    assign fwd_mask = wb_mask;
`else
    assign fwd_mask = '0;
`endif

    regfile_read_mux u_rd0 (.sel(rd0_sel), .regs(regs), .a(A), .f(F), .fwd_mask(fwd_mask), .fwd_bytes(wb_bytes), .data(ALU_input0));
    regfile_read_mux u_rd1 (.sel(rd1_sel), .regs(regs), .a(A), .f(F), .fwd_mask(fwd_mask), .fwd_bytes(wb_bytes), .data(ALU_input1));
    regfile_read_mux u_adr (.sel(addr_sel), .regs(regs), .a(A), .f(F), .fwd_mask(fwd_mask), .fwd_bytes(wb_bytes), .data(addr_out));

    // Direct write takes priority per lane; the rest of the writeback still lands.
    always_ff @(posedge clk4_2 or negedge reset_n) begin
        if (!reset_n) begin
            regs       <= {RESET_SP, {8{RESET_GPR}}};
            wb_pending <= 1'b0;
            wb_tgt     <= SEL_B;
        end else begin
            for (int i = 0; i < NUM_BYTES; i++)
                if (wr_mask[i]) regs[i] <= data_bus;
                else if (wb_mask[i]) regs[i] <= wb_bytes[i];
            wb_pending <= wb_req;
            if (wb_req) wb_tgt <= wb_sel;
        end
    end
endmodule

// File: tb/tb_cpu_regfile.sv
// tb_cpu_regfile: directed and randomized checks of cpu_regfile against a named-register model.
module tb_cpu_regfile;
    logic        clk4_2 = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  A = 8'h00, F = 8'h00, data_bus = 8'h00;
    logic [15:0] ALU_out = 16'h0000;
    logic [3:0]  rd0_sel = 4'd11, rd1_sel = 4'd8, addr_sel = 4'd10, wr_sel = 4'd0, wb_sel = 4'd0;
    logic        wr_en = 1'b0, wr_hi = 1'b0, wb_req = 1'b0;
    logic [15:0] ALU_input0, ALU_input1, addr_out;
    logic        wb_pending;

    int n_cmp = 0;
    int n_err = 0;

    // Model: B,C,D,E,H,L,W,Z by name index, SP as a word, plus the pending writeback.
    logic [7:0]  rb [8];
    logic [15:0] sp;
    logic        m_pend;
    logic [3:0]  m_tgt;
    logic [15:0] o0, o1, oa;

    cpu_regfile dut (
        .clk4_2(clk4_2), .reset_n(reset_n), .A(A), .F(F), .ALU_out(ALU_out), .data_bus(data_bus),
        .rd0_sel(rd0_sel), .rd1_sel(rd1_sel), .addr_sel(addr_sel), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_hi(wr_hi), .wb_req(wb_req), .wb_sel(wb_sel), .ALU_input0(ALU_input0),
        .ALU_input1(ALU_input1), .addr_out(addr_out), .wb_pending(wb_pending)
    );

    always #5 clk4_2 = ~clk4_2;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 8; i++) rb[i] = 8'h00;
        sp = 16'hFFFE;
        m_pend = 1'b0;
        m_tgt = 4'd0;
    endfunction

    // Names in select order: 0 B 1 C 2 D 3 E 4 H 5 L; rb[6] = W, rb[7] = Z.
    function automatic logic [15:0] m_read(input logic [3:0] s);
        case (s)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: return {8'h00, rb[s[2:0]]};
            4'd6:  return {8'h00, A};
            4'd7:  return {8'h00, F};
            4'd8:  return {rb[0], rb[1]};
            4'd9:  return {rb[2], rb[3]};
            4'd10: return {rb[4], rb[5]};
            4'd11: return sp;
            4'd12: return {A, F};
            4'd13: return {rb[6], rb[7]};
            4'd14: return {8'h00, rb[6]};
            default: return 16'h0000;
        endcase
    endfunction

    // Write high byte v[15:8] when wh, low byte v[7:0] when wl; single registers use wl.
    function automatic void m_set(input logic [3:0] s, input logic [15:0] v, input logic wh, input logic wl);
        case (s)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: if (wl) rb[s[2:0]] = v[7:0];
            4'd14: if (wl) rb[6] = v[7:0];
            4'd8:  begin if (wh) rb[0] = v[15:8]; if (wl) rb[1] = v[7:0]; end
            4'd9:  begin if (wh) rb[2] = v[15:8]; if (wl) rb[3] = v[7:0]; end
            4'd10: begin if (wh) rb[4] = v[15:8]; if (wl) rb[5] = v[7:0]; end
            4'd13: begin if (wh) rb[6] = v[15:8]; if (wl) rb[7] = v[7:0]; end
            4'd11: begin if (wh) sp[15:8] = v[15:8]; if (wl) sp[7:0] = v[7:0]; end
            default: ;
        endcase
    endfunction

    // What a read port should show now: forwarding means reading as if the pending write had landed.
    function automatic logic [15:0] m_view(input logic [3:0] s);
        logic [7:0]  sb [8];
        logic [15:0] ssp, r;
        sb = rb;
        ssp = sp;
`ifdef CPU_REGFILE_BYPASS_EN
        if (m_pend) m_set(m_tgt, ALU_out, 1'b1, 1'b1);
`endif
        r = m_read(s);
        rb = sb;
        sp = ssp;
        return r;
    endfunction

    task automatic cyc(input logic we, input logic [3:0] ws, input logic wh, input logic [7:0] db,
                       input logic wq, input logic [3:0] wbs, input logic [15:0] ao,
                       input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] sa,
                       output logic [15:0] r0, output logic [15:0] r1, output logic [15:0] ra);
        wr_en = we; wr_sel = ws; wr_hi = wh; data_bus = db;
        wb_req = wq; wb_sel = wbs; ALU_out = ao;
        rd0_sel = s0; rd1_sel = s1; addr_sel = sa;
        #4;
        r0 = ALU_input0; r1 = ALU_input1; ra = addr_out;
        check("rd0", ALU_input0, m_view(s0));
        check("rd1", ALU_input1, m_view(s1));
        check("addr", addr_out, m_view(sa));
        check("pending", {15'd0, wb_pending}, {15'd0, m_pend});
        @(posedge clk4_2);
        if (m_pend) m_set(m_tgt, ao, 1'b1, 1'b1);
        if (we) begin
            if (ws < 4'd8 || ws == 4'd14) m_set(ws, {8'h00, db}, 1'b0, 1'b1);
            else m_set(ws, {db, db}, wh, !wh);
        end
        m_pend = wq;
        if (wq) m_tgt = wbs;
        #1;
    endtask

    initial begin
        m_reset();
        #12;
        check("reset_sp", ALU_input0, 16'hFFFE);
        check("reset_bc", ALU_input1, 16'h0000);
        check("reset_pend", {15'd0, wb_pending}, 16'h0000);
        reset_n = 1'b1;
        @(posedge clk4_2);
        #1;
        // Byte-wise HL load then address readback
        cyc(1, 4'd10, 1, 8'hC0, 0, 0, 16'h0, 0, 1, 10, o0, o1, oa);
        cyc(1, 4'd10, 0, 8'h12, 0, 0, 16'h0, 0, 1, 10, o0, o1, oa);
        cyc(0, 0, 0, 8'h00, 0, 0, 16'h0, 4, 5, 10, o0, o1, oa);
        check("hl_bytes", oa, 16'hC012);
        // ALU writeback to DE
        cyc(0, 0, 0, 8'h00, 1, 4'd9, 16'h0000, 9, 8, 11, o0, o1, oa);
        cyc(0, 0, 0, 8'h00, 0, 0, 16'hBEEF, 9, 8, 11, o0, o1, oa);
        cyc(0, 0, 0, 8'h00, 0, 0, 16'h0000, 9, 8, 11, o0, o1, oa);
        check("wb_de", o0, 16'hBEEF);
        // Forwarding of a pending C writeback
        cyc(1, 4'd1, 0, 8'h77, 0, 0, 16'h0, 0, 8, 8, o0, o1, oa);
        cyc(0, 0, 0, 8'h00, 1, 4'd1, 16'h0, 0, 8, 8, o0, o1, oa);
        cyc(0, 0, 0, 8'h00, 0, 0, 16'h0055, 0, 8, 8, o0, o1, oa);
`ifdef CPU_REGFILE_BYPASS_EN
        check("bypass_bc", o1, 16'h0055);
`else
        check("bypass_bc", o1, 16'h0077);
`endif
        // Direct write to H collides with writeback to HL
        cyc(0, 0, 0, 8'h00, 1, 4'd10, 16'h0, 0, 1, 8, o0, o1, oa);
        cyc(1, 4'd4, 0, 8'hAA, 0, 0, 16'h1234, 0, 1, 8, o0, o1, oa);
        cyc(0, 0, 0, 8'h00, 0, 0, 16'h0, 10, 1, 10, o0, o1, oa);
        check("collide_hl", o0, 16'hAA34);
        // Reset while a writeback to E is pending
        cyc(1, 4'd3, 0, 8'h33, 0, 0, 16'h0, 3, 1, 8, o0, o1, oa);
        cyc(0, 0, 0, 8'h00, 1, 4'd3, 16'h0, 3, 1, 8, o0, o1, oa);
        wb_req = 1'b0; ALU_out = 16'h5A5A; rd0_sel = 4'd3;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_e", ALU_input0, 16'h0000);
        check("midrst_pend", {15'd0, wb_pending}, 16'h0000);
        m_reset();
        #2 reset_n = 1'b1;
        @(posedge clk4_2);
        #1;
        cyc(0, 0, 0, 8'h00, 0, 0, 16'h5A5A, 3, 11, 11, o0, o1, oa);
        check("after_rst_e", o0, 16'h0000);
        check("after_rst_sp", oa, 16'hFFFE);
        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            A = 8'($urandom);
            F = 8'($urandom);
            cyc(1'($urandom), 4'($urandom), 1'($urandom), 8'($urandom),
                1'($urandom), 4'($urandom), 16'($urandom),
                4'($urandom), 4'($urandom), 4'($urandom_range(8, 13)), o0, o1, oa);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
